ofdmbbp_dac_sequencer: RTL and testbench

Parametrised, single-clock sample sequencer between the OFDM BBP output and the ad9361 DAC interface. It buffers complex samples for NUM_CH channels in a circular buffer and prefills to a programmable level before playout. It then presents one sample set per dac_valid strobe. Unlike the previous fixed 1-channel path, it generates real underflow/overflow flags and keeps an underflow counter.

---
 rtl/ofdmbbp_dac_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ofdmbbp_dac_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ofdmbbp_dac_sequencer.sv
// OFDM BBP -> ad9361 DAC sample sequencer: circular prefill buffer, playout FSM,
// underflow/overflow flags. Optional build macro: OFDMBBP_SEQ_HOLD_LAST_EN (hold last sample on starvation).
module ofdmbbp_dac_sequencer #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int PREFILL    = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           enable,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CH*2*DATA_WIDTH-1:0] in_data,
    input  logic                           dac_valid,
    output logic [NUM_CH*2*DATA_WIDTH-1:0] dac_data,
    output logic                           dac_dunf,
    output logic                           dac_dovf,
    output logic [ADDR_WIDTH:0]            level,
    output logic [15:0]                    unf_count,
    input  logic                           clr_count
);

    localparam int SW    = NUM_CH * 2 * DATA_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_PRE  = (ADDR_WIDTH + 1)'(PREFILL);
    localparam logic [ADDR_WIDTH:0] LVL_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [SW-1:0]         mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [SW-1:0]         fill_data;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  unf;
    logic                  ovf;
    logic                  prefill_rd;

`ifdef OFDMBBP_SEQ_HOLD_LAST_EN
    // Starved strobes repeat the last sample set that was played out
    assign fill_data = dac_data;
`else
    // Starved strobes send silence to the DAC
    assign fill_data = '0;
`endif

    // Handshake and event decode, all from registered state
    always_comb begin
        flush      = 1'b0;
        in_ready   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        unf        = 1'b0;
        ovf        = 1'b0;
        prefill_rd = 1'b0;
        flush      = !enable || (state == S_IDLE);
        in_ready   = enable && (level != LVL_FULL) && (state != S_IDLE);
        push       = in_valid && in_ready;
        ovf        = in_valid && !in_ready && (state != S_IDLE);
        if (!flush) begin
            pop        = (state == S_RUN) && dac_valid && (level != LVL_ZERO);
            unf        = (state == S_RUN) && dac_valid && (level == LVL_ZERO);
            prefill_rd = (state == S_PREFILL) && dac_valid;
        end
    end

    // Next-state logic; disable overrides every transition
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_PREFILL;
            end
            S_PREFILL: begin
                if (level >= LVL_PRE) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (unf) state_nxt = S_PREFILL;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!enable) state_nxt = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Sample storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Pointers and occupancy, cleared whenever the path is flushed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // DAC output register: pop, fill on starvation, otherwise hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dac_data <= '0;
        end else if (flush) begin
            dac_data <= '0;
        end else if (pop) begin
            dac_data <= mem[rd_ptr];
        end else if (unf || prefill_rd) begin
            dac_data <= fill_data;
        end
    end

    // One-cycle status pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dac_dunf <= 1'b0;
            dac_dovf <= 1'b0;
        end else begin
            dac_dunf <= unf;
            dac_dovf <= ovf;
        end
    end

    // Saturating underflow counter; a clear coinciding with underflow leaves 1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            unf_count <= '0;
        end else if (clr_count) begin
            unf_count <= unf ? 16'd1 : 16'd0;
        end else if (unf && (unf_count != 16'hFFFF)) begin
            unf_count <= unf_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ofdmbbp_dac_sequencer.sv
// Self-checking bench for ofdmbbp_dac_sequencer: queue-based reference
// model driven by directed and $urandom stimulus.
module tb_ofdmbbp_dac_sequencer;

    localparam int NUM_CH = 2;
    localparam int DW     = 16;
    localparam int AW     = 4;
    localparam int PRE    = 8;
    localparam int DEPTH  = 16;
    localparam int SW     = NUM_CH * 2 * DW;
`ifdef OFDMBBP_SEQ_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef enum int {M_IDLE, M_PRE, M_RUN} mst_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_data;
    logic          dac_valid;
    logic [SW-1:0] dac_data;
    logic          dac_dunf;
    logic          dac_dovf;
    logic [AW:0]   level;
    logic [15:0]   unf_count;
    logic          clr_count;

    int n_assert = 0;
    int n_fail   = 0;

    mst_t          m_st;
    logic [SW-1:0] mq[$];
    logic [SW-1:0] m_data;
    logic          m_dunf;
    logic          m_dovf;
    logic [15:0]   m_cnt;

    ofdmbbp_dac_sequencer #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PREFILL(PRE)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dac_valid(dac_valid), .dac_data(dac_data),
        .dac_dunf(dac_dunf), .dac_dovf(dac_dovf),
        .level(level), .unf_count(unf_count), .clr_count(clr_count)
    );

    always #5 clk = ~clk;

    // One comparison point
    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sample set n: channel c has I = n + 1000*c, Q = -I
    function automatic logic [SW-1:0] mk(input int n);
        logic [SW-1:0] v;
        logic [DW-1:0] i;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            i = DW'(n + 1000 * c);
            v[c*2*DW +: 2*DW] = {-i, i};
        end
        return v;
    endfunction

    // Drive one cycle, advance the reference model, check all outputs
    task automatic step(input logic iv, input logic [SW-1:0] d,
                        input logic dv, input logic en, input logic clr,
                        output bit acc);
        bit   rdy;
        int   sz;
        mst_t cur;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        dac_valid = dv;
        enable    = en;
        clr_count = clr;
        #1;
        rdy = en && (mq.size() != DEPTH) && (m_st != M_IDLE);
        chk("in_ready", 64'(in_ready), 64'(rdy));
        acc    = iv && rdy;
        m_dovf = iv && !rdy && (m_st != M_IDLE);
        m_dunf = 1'b0;
        cur    = m_st;
        if (!en || cur == M_IDLE) begin
            mq.delete();
            m_data = '0;
            m_st   = en ? M_PRE : M_IDLE;
        end else begin
            sz = mq.size();
            if (cur == M_RUN && dv) begin
                if (sz == 0) begin
                    m_dunf = 1'b1;
                    if (!HOLD) m_data = '0;
                    m_st = M_PRE;
                end else begin
                    m_data = mq.pop_front();
                end
            end else if (cur == M_PRE && dv && !HOLD) begin
                m_data = '0;
            end
            if (acc) mq.push_back(d);
            if (cur == M_PRE && sz >= PRE) m_st = M_RUN;
        end
        if (clr)                             m_cnt = m_dunf ? 16'd1 : 16'd0;
        else if (m_dunf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        @(posedge clk);
        #1;
        chk("dac_data", 64'(dac_data), 64'(m_data));
        chk("dac_dunf", 64'(dac_dunf), 64'(m_dunf));
        chk("dac_dovf", 64'(dac_dovf), 64'(m_dovf));
        chk("level", 64'(level), 64'(mq.size()));
        chk("unf_count", 64'(unf_count), 64'(m_cnt));
    endtask

    initial begin
        bit acc;
        int n;
        rstn      = 1'b0;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        dac_valid = 1'b0;
        clr_count = 1'b0;
        m_st      = M_IDLE;
        m_data    = '0;
        m_dunf    = 1'b0;
        m_dovf    = 1'b0;
        m_cnt     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dac_data", 64'(dac_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_unf_count", 64'(unf_count), 64'd0);
        chk("rst_dunf", 64'(dac_dunf), 64'd0);
        chk("rst_dovf", 64'(dac_dovf), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Idle with traffic offered: nothing accepted, no flags
        for (int c = 0; c < 3; c++) step(1'b1, mk(99), 1'b1, 1'b0, 1'b0, acc);

        // Prefill then steady playout, strobe every second cycle
        n = 1;
        for (int c = 0; c < 40; c++) begin
            step((n <= PRE) || (c % 2 == 0), mk(n), 1'(c % 2), 1'b1, 1'b0, acc);
            if (acc) n++;
        end

        // Fill to the top with no reads; extra pushes are dropped
        for (int c = 0; c < 24; c++) begin
            step(1'b1, mk(n), 1'b0, 1'b1, 1'b0, acc);
            if (acc) n++;
        end

        // Drain, then starve with three more strobes
        for (int k = 0; k < 40 && mq.size() != 0; k++)
            step(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
        chk("unf_after_starve", 64'(unf_count), 64'd1);

        // Refill, then push and pop every cycle across pointer wrap
        for (int k = 0; k < 30 && m_st != M_RUN; k++) begin
            step(1'b1, mk(n), 1'b0, 1'b1, 1'b0, acc);
            if (acc) n++;
        end
        for (int c = 0; c < 40; c++) begin
            step(1'b1, mk(n), 1'b1, 1'b1, 1'b0, acc);
            if (acc) n++;
        end

        // Random traffic with occasional clear and disable
        for (int c = 0; c < 400; c++)
            step(1'($urandom % 4 != 0), {$urandom, $urandom},
                 1'($urandom % 2), 1'($urandom % 64 != 0),
                 1'($urandom % 50 == 0), acc);

        // Clear coinciding with an underflow
        for (int k = 0; k < 30 && m_st != M_RUN; k++)
            step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, acc);
        for (int k = 0; k < 40 && mq.size() != 0; k++)
            step(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc);
        chk("clr_with_unf", 64'(unf_count), 64'd1);

        // Disable at level 5, re-enable with fresh data
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        for (int k = 0; k < 20 && mq.size() != 5; k++)
            step(1'b1, mk(500 + k), 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        chk("disable_level", 64'(level), 64'd0);
        chk("disable_data", 64'(dac_data), 64'd0);
        n = 700;
        for (int c = 0; c < 40; c++) begin
            step(n < 712, mk(n), 1'(c >= 12), 1'b1, 1'b0, acc);
            if (acc) n++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
